// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store access unit driving a byte-addressed data RAM
// Requests are checked in IDLE, touch the RAM for exactly one ACCESS cycle, then wait in RESP.
module mem_access_unit #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_mode,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  state_t state, state_nxt;

  logic              lat_store;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_err;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_mode;
  logic [31:0]       hold_wdata;

  logic              req_err;
  logic              accept;
  logic              in_access;
  logic [31:0]       load_ext;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)
      req_err = 1'b1;
    if (req_size == SIZE_H && req_addr[0])
      req_err = 1'b1;
    if (req_size == SIZE_W && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ((req_addr >> ADDR_W) != 32'd0)
      req_err = 1'b1;
  end

  assign accept    = (state == S_IDLE) && req_valid;
  assign in_access = (state == S_ACCESS);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // RAM already right-aligns narrow lanes; only the upper bits need filling.
  always_comb begin
    load_ext = mem_rdata;
    case (lat_size)
      SIZE_B:  load_ext = {{24{mem_rdata[7] & ~lat_unsigned}}, mem_rdata[7:0]};
      SIZE_H:  load_ext = {{16{mem_rdata[15] & ~lat_unsigned}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Strobe is decoded from state so an asynchronous clr kills it at once.
  assign mem_we     = in_access && lat_store;
  assign mem_addr   = in_access ? lat_addr  : hold_addr;
  assign mem_mode   = in_access ? lat_size  : hold_mode;
  assign mem_wdata  = in_access ? lat_wdata : hold_wdata;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = lat_err;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= S_IDLE;
      lat_store    <= 1'b0;
      lat_size     <= SIZE_W;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_err      <= 1'b0;
      rdata_q      <= '0;
      hold_addr    <= '0;
      hold_mode    <= SIZE_W;
      hold_wdata   <= '0;
      load_cnt     <= '0;
      store_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_store    <= req_store;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr[ADDR_W-1:0];
        lat_wdata    <= req_wdata;
        lat_err      <= req_err;
        rdata_q      <= '0;
      end
      if (in_access) begin
        hold_addr  <= lat_addr;
        hold_mode  <= lat_size;
        hold_wdata <= lat_wdata;
        rdata_q    <= lat_store ? 32'd0 : load_ext;
      end
      if (state == S_RESP && resp_ready && !lat_err) begin
        if (lat_store)
          store_cnt <= store_cnt + 1'b1;
        else
          load_cnt <= load_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Expected responses are queued at request time and popped when the response appears.
module tb_mem_access_unit;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              clr;
  logic              req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_mode;
  logic              mem_we;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  load_cnt, store_cnt;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_loads = 0;
  int   exp_stores = 0;
  int   exp_we = 0;
  int   we_cnt = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_mode(mem_mode), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we === 1'b1) we_cnt <= we_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (a >= 32'h1000) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_ext(input logic [31:0] r, input logic [1:0] sz, input logic un);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = {24'h0, r[7:0]};
      if (!un && r[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, r[15:0]};
      if (!un && r[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_load_cnt"},  32'(load_cnt),  32'(exp_loads % 8));
    check({tag, "_store_cnt"}, 32'(store_cnt), 32'(exp_stores % 8));
    check({tag, "_we_pulses"}, 32'(we_cnt),    32'(exp_we));
  endtask

  task automatic run(input logic st, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int hold);
    exp_t e, got;
    logic err;
    int   n;
    @(negedge clk);
    err     = exp_err(sz, a);
    e.err   = err;
    e.rdata = (err || st) ? 32'd0 : exp_ext(rd, sz, un);
    sb.push_back(e);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; mem_rdata = rd;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = ~wd;
    if (!err) begin
      check("acc_mem_we",    32'(mem_we),    32'(st));
      check("acc_mem_addr",  32'(mem_addr),  32'(a[11:0]));
      check("acc_mem_mode",  32'(mem_mode),  32'(sz));
      check("acc_mem_wdata", mem_wdata,      wd);
      check("acc_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      if (st) exp_we++;
    end else begin
      check("err_no_we", 32'(mem_we), 32'd0);
    end
    check("resp_latency", 32'(resp_valid), 32'd1);
    n = 0;
    while (resp_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("resp_rdata", resp_rdata,        got.rdata);
      check("resp_err",   32'(resp_err),     32'(got.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_rdata", resp_rdata,      got.rdata);
        check("hold_ready", 32'(req_ready),  32'd0);
        check("hold_we",    32'(mem_we),     32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (!err) begin
      if (st) exp_stores++;
      else    exp_loads++;
    end
    check("back_idle", 32'(req_ready), 32'd1);
    check("resp_drop", 32'(resp_valid), 32'd0);
    check_counts("txn");
  endtask

  initial begin
    clr = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_mem_mode",   32'(mem_mode),   32'd2);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check_counts("rst");
    @(negedge clk);
    clr = 1'b0;

    run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    check("hold_mem_addr",  32'(mem_addr), 32'h010);
    check("hold_mem_wdata", mem_wdata,     32'hDEAD_BEEF);
    run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_00F0, 0);
    run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_00F0, 0);
    run(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_8001, 0);
    run(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000_8001, 0);
    run(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234_5678, 32'h0, 0);
    run(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h1111_1111, 0);
    run(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h2222_2222, 0);
    run(1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'hAB, 32'h0, 0);
    run(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 32'h8765_4321, 10);

    // clr during the ACCESS cycle of a store
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h44; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("clr_pre_we", 32'(mem_we), 32'd1);
    clr = 1'b1;
    #1;
    check("clr_we_async",   32'(mem_we),     32'd0);
    check("clr_mem_addr",   32'(mem_addr),   32'd0);
    check("clr_mem_mode",   32'(mem_mode),   32'd2);
    check("clr_mem_wdata",  mem_wdata,       32'd0);
    check("clr_resp_valid", 32'(resp_valid), 32'd0);
    check("clr_req_ready",  32'(req_ready),  32'd1);
    exp_loads = 0; exp_stores = 0;
    @(posedge clk); #1;
    check_counts("clr");
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_no_resp", 32'(resp_valid), 32'd0);

    run(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h0000_0080, 0);
    for (int i = 0; i < 9; i++)
      run(1'b0, 2'b10, 1'b1, 32'(i * 4), 32'h0, 32'(i) * 32'h0101_0101, 0);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, $urandom, $urandom_range(0, 2));
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
